// File: rtl/ram_loader.sv
// Load/verify controller: streams len words into a single-port RAM from address 0,
// then reads them back and compares XOR checksum and parity against the load.
module ram_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_bit,
  output logic                  busy,
  output logic                  done,
  output logic                  chk_ok,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [DATA_WIDTH-1:0] lsum_q, lsum_d;
  logic [DATA_WIDTH-1:0] vsum_q, vsum_d;
  logic                  lpar_q, lpar_d;
  logic                  vpar_q, vpar_d;
  logic                  chk_ok_q, chk_ok_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  logic                  hs_c;
  logic                  last_c;

  // The extra counter bit keeps a full-depth run from matching before its last word.
  assign hs_c   = s_valid && (state_q == S_LOAD);
  assign last_c = (cnt_q == (len_q - CNT_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs_c && last_c) begin
          state_d = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      S_VERIFY: begin
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  assign ram_we   = s_valid & s_ready;
  assign ram_addr = cnt_q[ADDR_WIDTH-1:0];
  assign ram_data = s_data;
  assign chk_ok   = chk_ok_q;
  assign checksum = checksum_q;

  // Counter, accumulators and result capture
  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    lsum_d     = lsum_q;
    vsum_d     = vsum_q;
    lpar_d     = lpar_q;
    vpar_d     = vpar_q;
    chk_ok_d   = chk_ok_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = len;
          cnt_d      = '0;
          lsum_d     = '0;
          vsum_d     = '0;
          lpar_d     = 1'b0;
          vpar_d     = 1'b0;
          checksum_d = '0;
          // An empty run enters DONE directly and is trivially consistent.
          chk_ok_d   = (len == '0);
        end
      end
      S_LOAD: begin
        if (hs_c) begin
          lsum_d = lsum_q ^ s_data;
          lpar_d = lpar_q ^ ram_bit;
          cnt_d  = last_c ? '0 : (cnt_q + CNT_W'(1));
        end
      end
      S_VERIFY: begin
        vsum_d = vsum_q ^ ram_rdata;
        vpar_d = vpar_q ^ (^ram_rdata);
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_c) begin
          cnt_d      = '0;
          chk_ok_d   = (vsum_d == lsum_q) && (vpar_d == lpar_q) && (lpar_q == (^lsum_q));
          checksum_d = lsum_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      len_q      <= '0;
      lsum_q     <= '0;
      vsum_q     <= '0;
      lpar_q     <= 1'b0;
      vpar_q     <= 1'b0;
      chk_ok_q   <= 1'b0;
      checksum_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      lsum_q     <= lsum_d;
      vsum_q     <= vsum_d;
      lpar_q     <= lpar_d;
      vpar_q     <= vpar_d;
      chk_ok_q   <= chk_ok_d;
      checksum_q <= checksum_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: directed runs push expected writes and results,
// a negedge monitor pops and compares whenever the DUT writes or pulses done.
module tb_ram_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_rdata;
  logic          ram_bit;
  logic          busy;
  logic          done;
  logic          chk_ok;
  logic [DW-1:0] checksum;

  always #5 clk = ~clk;

  ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_rdata (ram_rdata),
    .ram_bit   (ram_bit),
    .busy      (busy),
    .done      (done),
    .chk_ok    (chk_ok),
    .checksum  (checksum)
  );

  // RAM model with an optional one-shot corruption of address 1 once VERIFY starts
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic          corrupt_arm  = 1'b0;
  logic          corrupt_done = 1'b0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end else if (corrupt_arm && !corrupt_done && busy && !s_ready) begin
      mem[1]       <= mem[1] ^ 8'h01;
      corrupt_done <= 1'b1;
    end
  end

  assign ram_rdata = mem[ram_addr];
  assign ram_bit   = ^ram_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          ok;
    logic [DW-1:0] sum;
    int            cyc;
  } res_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  res_t          res_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] bq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_s_ready"},  32'(s_ready),  32'd0);
    chk({tag, "_ram_we"},   32'(ram_we),   32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_chk_ok"},   32'(chk_ok),   32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard
  initial begin
    wr_t  w;
    res_t r;
    forever begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", ram_addr, ram_data);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(w.a));
          chk("wr_data", 32'(ram_data), 32'(w.d));
        end
      end
      if (done === 1'b1) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: chk_ok %0d checksum 0x%0h, required no done", chk_ok, checksum);
        end else begin
          r = res_q.pop_front();
          chk("chk_ok",     32'(chk_ok),   32'(r.ok));
          chk("checksum",   32'(checksum), 32'(r.sum));
          chk("done_cycle", 32'(cyc),      32'(r.cyc));
        end
      end
    end
  end

  // One load/verify run; gap stall cycles are inserted between consecutive bytes
  task automatic run(input int L, input logic [DW-1:0] d[$], input int gap,
                     input bit keep_valid, input bit exp_ok);
    logic [DW-1:0] sum;
    int            e0;
    int            budget;
    res_t          r;
    wr_t           w;
    sum = '0;
    foreach (d[i]) sum ^= d[i];
    @(posedge clk); #1;
    start = 1'b1;
    len   = LW'(L);
    @(posedge clk); #1;
    start = 1'b0;
    len   = '1;
    e0    = cyc;
    r.ok  = exp_ok;
    r.sum = sum;
    r.cyc = e0 + 2 * L + ((L > 0) ? gap * (L - 1) : 0);
    res_q.push_back(r);
    for (int i = 0; i < L; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          s_valid = 1'b0;
          s_data  = 8'h00;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = d[i];
      w.a     = AW'(i);
      w.d     = d[i];
      wr_q.push_back(w);
      if (i == 0) begin
        @(negedge clk);
        chk("start_clears_chk_ok",   32'(chk_ok),   32'd0);
        chk("start_clears_checksum", 32'(checksum), 32'd0);
        chk("busy_in_load",          32'(busy),     32'd1);
      end
      @(posedge clk); #1;
    end
    s_valid = keep_valid;
    s_data  = 8'hEE;
    budget  = 2 * L + gap * L + 8;
    while (res_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    s_valid = 1'b0;
    n_checks++;
    if (res_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_timeout: no done within budget for len %0d", L);
      res_q.delete();
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    len     = '0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Basic run; valid stays high through VERIFY and must not cause writes
    bq = {8'h01, 8'h02, 8'h04, 8'h80};
    run(4, bq, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) chk("mem_run1", 32'(mem[i]), 32'(bq[i]));
    repeat (3) @(negedge clk);
    chk("held_chk_ok",   32'(chk_ok),   32'd1);
    chk("held_checksum", 32'(checksum), 32'h87);
    chk("idle_busy",     32'(busy),     32'd0);

    // Alternating valid stalls
    bq = {8'hA5, 8'h3C, 8'h0F};
    run(3, bq, 1, 1'b0, 1'b1);

    // Corrupted read-back at address 1
    corrupt_arm = 1'b1;
    bq = {8'h11, 8'h22, 8'h33, 8'h44};
    run(4, bq, 0, 1'b0, 1'b0);
    corrupt_arm = 1'b0;
    chk("corrupt_applied", 32'(mem[1]), 32'h23);

    // Empty run
    bq.delete();
    run(0, bq, 0, 1'b0, 1'b1);

    // Full-depth run, data equals address
    bq.delete();
    for (int i = 0; i < 256; i++) bq.push_back(8'(i));
    run(256, bq, 0, 1'b0, 1'b1);
    chk("mem_full_0",   32'(mem[0]),   32'h00);
    chk("mem_full_128", 32'(mem[128]), 32'h80);
    chk("mem_full_255", 32'(mem[255]), 32'hFF);

    // Reset on the third load handshake, then a fresh run
    begin
      wr_t w;
      @(posedge clk); #1;
      start = 1'b1;
      len   = LW'(5);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        s_valid = 1'b1;
        s_data  = 8'(8'h10 * (i + 1));
        w.a     = AW'(i);
        w.d     = s_data;
        wr_q.push_back(w);
        if (i == 2) rst = 1'b1;
        @(posedge clk); #1;
      end
      rst     = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      check_idle("mid_reset");
      chk("mid_reset_writes_drained", 32'(wr_q.size()), 32'd0);
      repeat (4) @(negedge clk);
    end
    bq = {8'h5A, 8'hC3};
    run(2, bq, 0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
